input_debounce: RTL

//  Multi-bit synchroniser plus glitch filter for asynchronous external levels (keys, GPIO, IRQ pins).

---
 rtl/input_debounce_pkg.sv | 7 +
 rtl/input_debounce_bit.sv | 67 ++++++
 rtl/input_debounce.sv | 37 +++
 3 files changed

// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg: shared FSM state encoding for the debounce slice
package input_debounce_pkg;
  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_QUALIFY = 1'b1
  } db_state_e;
endpackage

// File: rtl/input_debounce_bit.sv
// input_debounce_bit: synchroniser + qualify FSM + counter for one input bit
// Ports: clk/rstn (async active-low), a raw input, en filter enable, tick sample strobe,
//        cfg_thresh qualify length in ticks, y debounced level, busy high while qualifying.
module input_debounce_bit
  import input_debounce_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 16,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             a,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             y,
  output logic             busy
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  db_state_e              state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   y_n;
  logic [CNT_W:0]         cnt_inc;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], a};
  assign s = sync_q[SYNC_STAGES-1];
  // one extra bit so cnt + 1 never wraps before the compare
  assign cnt_inc = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= ST_STABLE;
      cnt   <= '0;
      y     <= RST_VAL;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      y     <= y_n;
    end
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    y_n     = y;
    if (!en) begin
      state_n = ST_STABLE;
      cnt_n   = '0;
    end else if (state == ST_STABLE) begin
      if (s != y) begin
        if (cfg_thresh == '0) y_n = s;
        else begin
          state_n = ST_QUALIFY;
          cnt_n   = '0;
        end
      end
    end else if (s == y) begin
      state_n = ST_STABLE;
      cnt_n   = '0;
    end else if (tick && cnt_inc >= {1'b0, cfg_thresh}) begin
      y_n     = s;
      state_n = ST_STABLE;
      cnt_n   = '0;
    end else if (tick) cnt_n = cnt_inc[CNT_W-1:0];
  end
  assign busy = (state == ST_QUALIFY);
endmodule

// File: rtl/input_debounce.sv
// input_debounce: multi-bit synchroniser and glitch filter for asynchronous levels
// Ports: clk/rstn (async active-low), A raw inputs, en filter enable, tick sample strobe,
//        cfg_thresh qualify length in ticks, Y debounced levels, busy per-bit qualify flag.
module input_debounce
  import input_debounce_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               SYNC_STAGES = 2,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] A,
  input  logic             en,
  input  logic             tick,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] busy
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    input_debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .RST_VAL    (RST_VAL[i])
    ) u_bit (
      .clk       (clk),
      .rstn      (rstn),
      .a         (A[i]),
      .en        (en),
      .tick      (tick),
      .cfg_thresh(cfg_thresh),
      .y         (Y[i]),
      .busy      (busy[i])
    );
  end
endmodule
